// File: rtl/whack_defs.sv
// ============================================================================
// Module      : whack_defs (package)
// Description : Definitions shared by the whack-a-mole blocks. It holds the
//               judge state encodings, the default hole count and hit-window
//               length, and the score width used by the score counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package whack_defs;

    // Judge FSM state encodings
    localparam logic [1:0] MJ_IDLE    = 2'd0;
    localparam logic [1:0] MJ_ACTIVE  = 2'd1;
    localparam logic [1:0] MJ_RELEASE = 2'd2;

    // Game defaults
    localparam int DEF_NUM_HOLES     = 4;
    localparam int DEF_WINDOW_CYCLES = 100000000;

    // Width of the score counter fed by increment/decrement
    localparam int SCORE_W = 8;

endpackage : whack_defs

`default_nettype wire

// File: rtl/mole_judge_rise_detect.sv
// ============================================================================
// Module      : mole_judge_rise_detect
// Description : Parameterised rising-edge detector. It registers the input
//               levels every cycle and flags each bit that goes from 0 to 1.
//               The same block serves the start/reset buttons.
// Ports       : clk    - system clock
//               reset  - asynchronous, active-high reset (clears history)
//               level  - synchronised input levels
//               rise   - level & ~previous level (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mole_judge_rise_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= '0;
        end else begin
            r_prev <= level;
        end
    end

    assign rise = level & ~r_prev;

endmodule : mole_judge_rise_detect

`default_nettype wire

// File: rtl/mole_judge.sv
// ============================================================================
// Module      : mole_judge
// Description : Whack-a-mole judge. It accepts a new mole position, lights
//               the matching LED and opens a timed hit window. Button presses
//               are then judged and turned into one-cycle increment or
//               decrement pulses for the score counter.
//               Optional macro MOLE_JUDGE_IDLE_PENALTY_EN: a button rise
//               while idle produces a decrement, unless a mole is accepted in
//               that same cycle.
// Ports       : clk        - system clock
//               reset      - asynchronous, active-high reset
//               mole_valid - one-cycle request for a new mole at mole_pos
//               mole_pos   - hole index of the new mole
//               btn        - debounced, synchronised button levels
//               mole_ready - high while idle (a new mole is accepted)
//               mole_led   - one-hot lit mole, 0 when there is no mole
//               increment  - one-cycle hit pulse
//               decrement  - one-cycle penalty pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mole_judge
    import whack_defs::*;
#(
    parameter int NUM_HOLES     = DEF_NUM_HOLES,
    parameter int HOLE_W        = 2,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int TIMER_W       = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mole_valid,
    input  logic [HOLE_W-1:0]    mole_pos,
    input  logic [NUM_HOLES-1:0] btn,
    output logic                 mole_ready,
    output logic [NUM_HOLES-1:0] mole_led,
    output logic                 increment,
    output logic                 decrement
);

    localparam logic [TIMER_W-1:0]   c_timer_load = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   c_timer_one  = TIMER_W'(1);
    localparam logic [HOLE_W:0]      c_num_holes  = (HOLE_W + 1)'(NUM_HOLES);
    localparam logic [NUM_HOLES-1:0] c_one_hot0   = NUM_HOLES'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic [HOLE_W-1:0]    r_pos;
    logic [HOLE_W-1:0]    w_pos_nxt;
    logic [NUM_HOLES-1:0] r_led;
    logic [NUM_HOLES-1:0] w_led_nxt;
    logic                 r_inc;
    logic                 w_inc_nxt;
    logic                 r_dec;
    logic                 w_dec_nxt;

    logic [NUM_HOLES-1:0] w_rise;
    logic [NUM_HOLES-1:0] w_target;
    logic                 w_mole_ok;
    logic                 w_any_wrong;
    logic                 w_hit;
    logic                 w_timeout;

    // ------------------------------------------------------------------------
    // Button edge detection (history is kept in every state)
    // ------------------------------------------------------------------------
    mole_judge_rise_detect #(
        .WIDTH (NUM_HOLES)
    ) u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .level (btn),
        .rise  (w_rise)
    );

    // ------------------------------------------------------------------------
    // Decision terms
    // ------------------------------------------------------------------------
    // Positions beyond the last hole are not valid moles; the zero-extended
    // compare also covers HOLE_W wider than strictly needed.
    assign w_mole_ok   = mole_valid && ({1'b0, mole_pos} < c_num_holes);
    assign w_target    = c_one_hot0 << r_pos;
    // Any rise off-target loses, even alongside a correct rise (anti-mash).
    assign w_any_wrong = |(w_rise & ~w_target);
    assign w_hit       = |(w_rise & w_target);
    assign w_timeout   = (r_timer == '0);

    // ------------------------------------------------------------------------
    // State register (with the registered outputs)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MJ_IDLE;
            r_timer <= '0;
            r_pos   <= '0;
            r_led   <= '0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_pos   <= w_pos_nxt;
            r_led   <= w_led_nxt;
            r_inc   <= w_inc_nxt;
            r_dec   <= w_dec_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_pos_nxt   = r_pos;
        case (r_state)
            MJ_IDLE: begin
                if (w_mole_ok) begin
                    w_state_nxt = MJ_ACTIVE;
                    w_timer_nxt = c_timer_load;
                    w_pos_nxt   = mole_pos;
                end
            end
            MJ_ACTIVE: begin
                // A press of either kind ends the window, so a correct rise
                // on the timer==0 cycle still counts as a hit.
                if (w_any_wrong || w_hit) begin
                    w_state_nxt = MJ_RELEASE;
                    w_timer_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt = MJ_IDLE;
                end else begin
                    w_timer_nxt = r_timer - c_timer_one;
                end
            end
            MJ_RELEASE: begin
                if (btn == '0) begin
                    w_state_nxt = MJ_IDLE;
                end
            end
            default: begin
                w_state_nxt = MJ_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: mole_ready directly, the rest as next values of the
    // output registers so every pulse lands one cycle after its decision.
    // ------------------------------------------------------------------------
    always_comb begin
        mole_ready = (r_state == MJ_IDLE);
        w_led_nxt  = '0;
        w_inc_nxt  = 1'b0;
        w_dec_nxt  = 1'b0;
        case (r_state)
            MJ_IDLE: begin
                if (w_mole_ok) begin
                    w_led_nxt = c_one_hot0 << mole_pos;
                end
`ifdef MOLE_JUDGE_IDLE_PENALTY_EN
                else if (|w_rise) begin
                    w_dec_nxt = 1'b1;
                end
`endif
            end
            MJ_ACTIVE: begin
                if (w_any_wrong) begin
                    w_dec_nxt = 1'b1;
                end else if (w_hit) begin
                    w_inc_nxt = 1'b1;
                end else if (w_timeout) begin
                    w_dec_nxt = 1'b1;
                end else begin
                    w_led_nxt = r_led;
                end
            end
            default: begin
                w_led_nxt = '0;
            end
        endcase
    end

    assign mole_led  = r_led;
    assign increment = r_inc;
    assign decrement = r_dec;

endmodule : mole_judge

`default_nettype wire

// File: tb/tb_mole_judge.sv
// ============================================================================
// Module      : tb_mole_judge
// Description : Self-checking bench for mole_judge with NUM_HOLES=4,
//               HOLE_W=3 and WINDOW_CYCLES=8. A table of vectors is driven
//               one per clock, with hand-written sequences for reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mole_judge;

    localparam int NUM_HOLES     = 4;
    localparam int HOLE_W        = 3;
    localparam int WINDOW_CYCLES = 8;
    localparam int TIMER_W       = 4;

`ifdef MOLE_JUDGE_IDLE_PENALTY_EN
    localparam logic c_idle_dec = 1'b1;
`else
    localparam logic c_idle_dec = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 mole_valid;
    logic [HOLE_W-1:0]    mole_pos;
    logic [NUM_HOLES-1:0] btn;
    logic                 mole_ready;
    logic [NUM_HOLES-1:0] mole_led;
    logic                 increment;
    logic                 decrement;

    mole_judge #(
        .NUM_HOLES     (NUM_HOLES),
        .HOLE_W        (HOLE_W),
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .TIMER_W       (TIMER_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mole_valid (mole_valid),
        .mole_pos   (mole_pos),
        .btn        (btn),
        .mole_ready (mole_ready),
        .mole_led   (mole_led),
        .increment  (increment),
        .decrement  (decrement)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 mv;
        logic [HOLE_W-1:0]    pos;
        logic [NUM_HOLES-1:0] btn;
        logic                 ready;
        logic [NUM_HOLES-1:0] led;
        logic                 inc;
        logic                 dec;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic mv, input logic [HOLE_W-1:0] pos,
                       input logic [NUM_HOLES-1:0] b, input logic rdy,
                       input logic [NUM_HOLES-1:0] led, input logic inc,
                       input logic dec);
        vec_t v;
        v.mv = mv; v.pos = pos; v.btn = b;
        v.ready = rdy; v.led = led; v.inc = inc; v.dec = dec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic rdy,
                       input logic [NUM_HOLES-1:0] led, input logic inc,
                       input logic dec);
        n_vec++;
        if (mole_ready !== rdy) begin
            n_miss++;
            $display("FAIL %s mole_ready: got %b want %b", name, mole_ready, rdy);
        end
        if (mole_led !== led) begin
            n_miss++;
            $display("FAIL %s mole_led: got %b want %b", name, mole_led, led);
        end
        if (increment !== inc) begin
            n_miss++;
            $display("FAIL %s increment: got %b want %b", name, increment, inc);
        end
        if (decrement !== dec) begin
            n_miss++;
            $display("FAIL %s decrement: got %b want %b", name, decrement, dec);
        end
    endtask

    initial begin
        // ---- vector table: inputs for one cycle, outputs after that edge ----
        // Hit on hole 2 on the third ACTIVE cycle, then release
        add(1, 2, 4'b0000, 0, 4'b0100, 0, 0);
        add(0, 0, 4'b0000, 0, 4'b0100, 0, 0);
        add(0, 0, 4'b0000, 0, 4'b0100, 0, 0);
        add(0, 0, 4'b0100, 0, 4'b0000, 1, 0);
        add(0, 0, 4'b0100, 0, 4'b0000, 0, 0);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 0);
        // Mash: correct hole 1 plus wrong hole 0 -> decrement only
        add(1, 1, 4'b0000, 0, 4'b0010, 0, 0);
        add(0, 0, 4'b0011, 0, 4'b0000, 0, 1);
        add(0, 0, 4'b0011, 0, 4'b0000, 0, 0);
        add(0, 0, 4'b0001, 0, 4'b0000, 0, 0);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 0);
        // Timeout: decrement on the 8th edge after acceptance
        add(1, 0, 4'b0000, 0, 4'b0001, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 4'b0000, 0, 4'b0001, 0, 0);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 1);
        // Correct press on the last window cycle counts as a hit
        add(1, 0, 4'b0000, 0, 4'b0001, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 4'b0000, 0, 4'b0001, 0, 0);
        add(0, 0, 4'b0001, 0, 4'b0000, 1, 0);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 0);
        // Held button: press in IDLE, held into the window, no re-trigger
        add(0, 0, 4'b1000, 1, 4'b0000, 0, c_idle_dec);
        add(1, 3, 4'b1000, 0, 4'b1000, 0, 0);
        add(0, 0, 4'b1000, 0, 4'b1000, 0, 0);
        add(0, 0, 4'b0000, 0, 4'b1000, 0, 0);
        add(0, 0, 4'b1000, 0, 4'b0000, 1, 0);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 0);
        // Ignored requests: out-of-range pos in IDLE, any pos during ACTIVE
        add(1, 5, 4'b0000, 1, 4'b0000, 0, 0);
        add(1, 1, 4'b0000, 0, 4'b0010, 0, 0);
        add(1, 3, 4'b0000, 0, 4'b0010, 0, 0);
        add(0, 0, 4'b0100, 0, 4'b0000, 0, 1);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 0);
        // Rise with an accepted mole in IDLE: never a penalty
        add(1, 2, 4'b0001, 0, 4'b0100, 0, 0);
        add(0, 0, 4'b0000, 0, 4'b0100, 0, 0);
        add(0, 0, 4'b0110, 0, 4'b0000, 0, 1);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 0);
        // Rise with a rejected request in IDLE: penalty only with the option
        add(1, 7, 4'b0010, 1, 4'b0000, 0, c_idle_dec);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 0);

        // ---- reset ----
        reset = 1'b1; mole_valid = 1'b0; mole_pos = '0; btn = '0;
        repeat (2) @(posedge clk);
        #1 chk("reset_state", 1, 4'b0000, 0, 0);
        @(negedge clk) reset = 1'b0;

        // ---- table ----
        foreach (vecs[i]) begin
            @(negedge clk);
            mole_valid = vecs[i].mv;
            mole_pos   = vecs[i].pos;
            btn        = vecs[i].btn;
            @(posedge clk);
            #1 chk($sformatf("vec%0d", i), vecs[i].ready, vecs[i].led,
                   vecs[i].inc, vecs[i].dec);
        end

        // ---- asynchronous reset in the middle of a window ----
        @(negedge clk) mole_valid = 1'b1; mole_pos = 3'd2; btn = '0;
        @(posedge clk) #1 mole_valid = 1'b0;
        chk("mid_accept", 0, 4'b0100, 0, 0);
        @(negedge clk) #2 reset = 1'b1;
        #1 chk("mid_reset_async", 1, 4'b0000, 0, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1 chk("after_reset_idle", 1, 4'b0000, 0, 0);

        // ---- asynchronous reset while an increment pulse is high ----
        @(negedge clk) mole_valid = 1'b1; mole_pos = 3'd1;
        @(posedge clk) #1 mole_valid = 1'b0;
        @(negedge clk) btn = 4'b0010;
        @(posedge clk) #1 chk("pulse_before_reset", 0, 4'b0000, 1, 0);
        #1 reset = 1'b1;
        #1 chk("pulse_killed", 1, 4'b0000, 0, 0);
        @(negedge clk) btn = '0; reset = 1'b0;
        @(posedge clk) #1 chk("final_idle", 1, 4'b0000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_mole_judge

`default_nettype wire

// File: doc/mole_judge.md
Name: mole_judge

Overview:
- Produces the score counter's increment/decrement pulses from game events.
- Latches a new mole position, drives the mole LEDs, and opens a timed hit window.
- Judges button presses: correct hole gives increment, wrong hole or timeout gives decrement.
- Sits between the mole generator / debounced buttons and the 8-bit score counter.

Parameters:
- NUM_HOLES, 4, number of holes/buttons (2..16).
- HOLE_W, 2, width of mole_pos; must satisfy 2^HOLE_W >= NUM_HOLES.
- WINDOW_CYCLES, 100000000, hit window length in clk cycles (>= 2).
- TIMER_W, 27, timer width; must hold WINDOW_CYCLES-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- mole_valid  input  1  one-cycle request: new mole at mole_pos
- mole_pos  input  HOLE_W  hole index of new mole
- btn  input  NUM_HOLES  debounced, synchronised button levels
- mole_ready  output  1  high in IDLE (new mole accepted)
- mole_led  output  NUM_HOLES  one-hot lit mole; 0 when no mole
- increment  output  1  one-cycle hit pulse to score counter
- decrement  output  1  one-cycle penalty pulse to score counter

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE, mole_led=0, increment=0, decrement=0, timer=0, btn_prev=0.
- Reset mid-window aborts the window. No pulse is emitted, and mole_led clears immediately.
- Edge detection: rise = btn & ~btn_prev. btn_prev registers btn every cycle in all states.
- Outputs increment, decrement and mole_led are registered.
- increment and decrement are never high together and are never high longer than one cycle.
- States: IDLE, ACTIVE, RELEASE.
- IDLE:
  - mole_ready=1.
  - On mole_valid with mole_pos < NUM_HOLES: latch pos, set mole_led one-hot, load timer=WINDOW_CYCLES-1, go to ACTIVE.
  - mole_valid with mole_pos >= NUM_HOLES is ignored and the state stays IDLE.
  - Button rises are ignored (see optional feature).
- ACTIVE:
  - mole_ready=0. mole_valid is ignored, not queued.
  - Timer decrements each cycle. Priority, highest first:
  - (a) Any rise on a wrong hole, even with a simultaneous correct rise: decrement pulse, clear mole_led, go to RELEASE. This is the anti-mash rule.
  - (b) Rise on the correct hole only: increment pulse, clear mole_led, go to RELEASE.
  - (c) timer==0 with no rise: miss. Decrement pulse, clear mole_led, go to IDLE.
- Window length: ACTIVE lasts exactly WINDOW_CYCLES cycles if no press occurs.
- A correct rise in the same cycle as timer==0 counts as a hit.
- Pulse latency: the pulse is high in the cycle after the clock edge that first samples the deciding rise or timer==0.
- RELEASE: wait until btn==0 (all buttons released), then go to IDLE the next edge. No pulses are issued in RELEASE.
- Buttons held through RELEASE into IDLE do not re-trigger, because a rise requires a 0->1 change.
- Counter saturation/wrap is the counter's responsibility; this block does not track the score.

Optional Feature:
- Macro: MOLE_JUDGE_IDLE_PENALTY_EN.
- Defined: any button rise in IDLE produces a one-cycle decrement. State stays IDLE.
  - If mole_valid arrives in the same cycle, the mole is accepted and no penalty is issued.
- Undefined: button rises in IDLE have no effect.

Decomposition:
- Shared package/include whack_defs:
  - state encodings MJ_IDLE=2'd0, MJ_ACTIVE=2'd1, MJ_RELEASE=2'd2;
  - default NUM_HOLES and WINDOW_CYCLES;
  - score width 8, shared with the counter.
- One natural sub-module: rise_detect. It is a parameterised-width register plus AND-NOT, with async reset, and is reused for the start/reset buttons elsewhere.

Test Plan (NUM_HOLES=4, WINDOW_CYCLES=8):
- Hit: mole_valid, pos=2; btn=4'b0100 at cycle 3 -> increment one cycle, mole_led 4'b0100->0. After release, mole_ready=1.
- Wrong/mash: pos=1; btn=4'b0011 in one cycle -> decrement only, no increment. mole_ready stays 0 until btn=0.
- Timeout: pos=0, no buttons -> decrement exactly 8 cycles after acceptance, then IDLE. Correct press on cycle 8 instead -> increment.
- Held button: hold btn[3] from IDLE, then mole_valid pos=3 -> no pulse until release and re-press. Then increment.
- Ignored requests: mole_valid pos=3 during ACTIVE, or pos=5 with HOLE_W=3 in IDLE -> no state or LED change.
- Reset mid-window: assert reset asynchronously in ACTIVE -> mole_led, increment, decrement go to 0 immediately. With the macro defined, an IDLE press -> decrement.
